// File: rtl/fmdll_frame_counter_if.sv
// Bus between the FMDLL frame counter and its user (select logic / config).
// The master drives the reference clock sample, enable and the N/M config;
// the slave (the counter) returns the counters, divider strobes and lock status.
interface fmdll_frame_counter_if #(
  parameter int N_W = 4,
  parameter int M_W = 2
);
  logic           clk_ext;
  logic           en;
  logic [N_W-1:0] N;
  logic [M_W-1:0] M;
  logic [N_W-1:0] N_counter;
  logic [M_W-1:0] M_counter;
  logic           DIV_N;
  logic           DIV_M;
  logic           locked;
  logic           phase_err;

  modport master (
    output clk_ext, en, N, M,
    input  N_counter, M_counter, DIV_N, DIV_M, locked, phase_err
  );

  modport slave (
    input  clk_ext, en, N, M,
    output N_counter, M_counter, DIV_N, DIV_M, locked, phase_err
  );
endinterface

// File: rtl/fmdll_frame_counter.sv
// Cycle/frame counter running on the FMDLL output clock. Counts N cycles per
// sub-frame and M sub-frames per frame, aligns frame start to rising edges of
// the synchronised reference clock and reports lock / phase errors.
module fmdll_frame_counter #(
  parameter int N_W         = 4,
  parameter int M_W         = 2,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                  clk_out,
  input  logic                  rst_n,
  fmdll_frame_counter_if.slave  bus
);
  localparam int LC_W = $clog2(LOCK_FRAMES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state_reg, state_next;
  logic [N_W-1:0]         n_cnt_reg, n_cnt_next;
  logic [M_W-1:0]         m_cnt_reg, m_cnt_next;
  logic [N_W-1:0]         n_s_reg, n_s_next;
  logic [M_W-1:0]         m_s_reg, m_s_next;
  logic [LC_W-1:0]        lock_cnt_reg, lock_cnt_next;
  logic                   locked_reg, locked_next;
  logic                   phase_err_reg, phase_err_next;
  logic                   div_n_reg, div_n_next;
  logic                   div_m_reg, div_m_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   ext_prev_reg;

  logic                   ext_rise;
  logic                   boundary;
  logic                   realign;
  logic                   frame_start;
  logic [N_W-1:0]         n_load;
  logic [M_W-1:0]         m_load;

  // A programmed value of 0 means "one" so a sub-frame / frame is never empty.
  assign n_load   = (bus.N == '0) ? N_W'(1) : bus.N;
  assign m_load   = (bus.M == '0) ? M_W'(1) : bus.M;

  // Rising edge of the reference clock, seen after the synchroniser.
  assign ext_rise = sync_reg[SYNC_STAGES-1] & ~ext_prev_reg;

  // Natural frame boundary: last cycle of the last sub-frame.
  assign boundary = (n_cnt_reg == n_s_reg) && (m_cnt_reg == m_s_reg);

  // clk_ext synchroniser chain plus edge-detect history flop.
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg     <= '0;
      ext_prev_reg <= 1'b0;
    end else begin
      if (SYNC_STAGES > 1) begin
        sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.clk_ext};
      end else begin
        sync_reg <= SYNC_STAGES'(bus.clk_ext);
      end
      ext_prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  // State, counters, shadow config and registered outputs.
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      n_cnt_reg     <= '0;
      m_cnt_reg     <= '0;
      n_s_reg       <= N_W'(1);
      m_s_reg       <= M_W'(1);
      lock_cnt_reg  <= '0;
      locked_reg    <= 1'b0;
      phase_err_reg <= 1'b0;
      div_n_reg     <= 1'b0;
      div_m_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      n_cnt_reg     <= n_cnt_next;
      m_cnt_reg     <= m_cnt_next;
      n_s_reg       <= n_s_next;
      m_s_reg       <= m_s_next;
      lock_cnt_reg  <= lock_cnt_next;
      locked_reg    <= locked_next;
      phase_err_reg <= phase_err_next;
      div_n_reg     <= div_n_next;
      div_m_reg     <= div_m_next;
    end
  end

  // Next-state: counting, alignment/lock tracking and divider strobes.
  always_comb begin
    state_next     = state_reg;
    n_cnt_next     = n_cnt_reg;
    m_cnt_next     = m_cnt_reg;
    n_s_next       = n_s_reg;
    m_s_next       = m_s_reg;
    lock_cnt_next  = lock_cnt_reg;
    locked_next    = locked_reg;
    phase_err_next = 1'b0;
    realign        = 1'b0;
    frame_start    = 1'b0;

    case (state_reg)
      IDLE: begin
        n_cnt_next    = '0;
        m_cnt_next    = '0;
        lock_cnt_next = '0;
        locked_next   = 1'b0;
        if (bus.en) begin
          state_next  = RUN;
          frame_start = 1'b1;
        end
      end
      RUN: begin
        if (!bus.en) begin
          // Disable wins over any alignment event in the same cycle.
          state_next    = IDLE;
          n_cnt_next    = '0;
          m_cnt_next    = '0;
          lock_cnt_next = '0;
          locked_next   = 1'b0;
        end else begin
          if (!locked_reg) begin
            if (ext_rise) begin
              // Acquire: every reference edge restarts the frame; edges that
              // already land on a boundary count towards lock.
              realign = 1'b1;
              if (boundary) begin
                lock_cnt_next = lock_cnt_reg + LC_W'(1);
                if (lock_cnt_reg + LC_W'(1) == LC_W'(LOCK_FRAMES)) begin
                  locked_next = 1'b1;
                end
              end else begin
                lock_cnt_next = '0;
              end
            end else if (boundary) begin
              lock_cnt_next = '0;
            end
          end else if (ext_rise != boundary) begin
            // Lost alignment: flag it, drop lock and keep free-running.
            phase_err_next = 1'b1;
            locked_next    = 1'b0;
            lock_cnt_next  = '0;
          end

          if (realign || boundary) begin
            frame_start = 1'b1;
          end else if (n_cnt_reg == n_s_reg) begin
            n_cnt_next = N_W'(1);
            m_cnt_next = m_cnt_reg + M_W'(1);
          end else begin
            n_cnt_next = n_cnt_reg + N_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // New frame: restart counters and pick up the current N/M.
    if (frame_start) begin
      n_cnt_next = N_W'(1);
      m_cnt_next = M_W'(1);
      n_s_next   = n_load;
      m_s_next   = m_load;
    end

    div_n_next = (state_next == RUN) && (n_cnt_next == n_s_next);
    div_m_next = div_n_next && (m_cnt_next == m_s_next);
  end

  assign bus.N_counter = n_cnt_reg;
  assign bus.M_counter = m_cnt_reg;
  assign bus.DIV_N     = div_n_reg;
  assign bus.DIV_M     = div_m_reg;
  assign bus.locked    = locked_reg;
  assign bus.phase_err = phase_err_reg;
endmodule
